// File: rtl/fft_stage_ctrl.sv
// Rank sequencer for the 4-stage radix-2 16-point FFT with per-rank occupancy.
// Optional perf counters: define FFT_STAGE_CTRL_PERF_CNT_EN.
module fft_stage_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_valid,
    input  logic             out_ready,
    input  logic             flush,
    input  logic             err_clr,
    output logic [3:0]       stage_en,
    output logic             fft_valid,
    output logic             busy,
    output logic             drop_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    logic       pend_q;
    logic       pend_d;
    logic [4:1] v_q;
    logic [4:1] v_d;
    logic       drop_err_q;
    logic       drop_err_d;
    logic [3:0] en;
    logic       drop;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= 1'b0;
            v_q        <= '0;
            drop_err_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            v_q        <= v_d;
            drop_err_q <= drop_err_d;
        end
    end

    // A rank may load when it is empty or its contents move on this cycle
    always_comb begin
        en    = '0;
        en[0] = v_q[3] & (~v_q[4] | out_ready);
        en[1] = v_q[2] & (~v_q[3] | en[0]);
        en[2] = v_q[1] & (~v_q[2] | en[1]);
        en[3] = pend_q & (~v_q[1] | en[2]);
    end

    // Next-state
    always_comb begin
        pend_d     = pend_q;
        v_d        = v_q;
        drop       = x_valid & pend_q & ~en[3] & ~flush;
        drop_err_d = drop | (drop_err_q & ~err_clr);
        if (flush) begin
            pend_d = 1'b0;
            v_d    = '0;
        end else begin
            pend_d = x_valid | (pend_q & ~en[3]);
            v_d[1] = en[3] | (v_q[1] & ~en[2]);
            v_d[2] = en[2] | (v_q[2] & ~en[1]);
            v_d[3] = en[1] | (v_q[3] & ~en[0]);
            v_d[4] = en[0] | (v_q[4] & ~out_ready);
        end
    end

    // Outputs
    always_comb begin
        stage_en  = flush ? 4'b0000 : en;
        fft_valid = v_q[4];
        busy      = pend_q | (|v_q);
        drop_err  = drop_err_q;
    end

`ifdef FFT_STAGE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] frame_q;
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
            stall_q <= '0;
        end else begin
            if (v_q[4] & out_ready)
                frame_q <= frame_q + 1'b1;
            if (v_q[4] & ~out_ready)
                stall_q <= stall_q + 1'b1;
        end
    end

    assign frame_cnt = frame_q;
    assign stall_cnt = stall_q;
`else
    assign frame_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule
